// File: rtl/cpu_defs.sv
// Shared definitions for the memory arbiter: data/address widths, FSM encoding and the
// default fairness limit.
package cpu_defs;

    localparam int unsigned ADR_W          = 8;
    localparam int unsigned DAT_W          = 16;
    localparam int unsigned CNT_W          = 3;
    localparam int unsigned FAIR_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } arb_st_t;

endpackage

// File: rtl/arb_fair_cnt.sv
// Fairness counter: counts CPU grants taken while the loader waits and raises force_ldr
// once the count reaches FAIR_LIMIT.
module arb_fair_cnt
    import cpu_defs::*;
#(
    parameter int unsigned FAIR_LIMIT = FAIR_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             idle,
    input  logic             cpu_req,
    input  logic             ldr_req,
    output logic [CNT_W-1:0] fair_cnt,
    output logic             force_ldr
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAIR_LIMIT);

    assign force_ldr = (fair_cnt == LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fair_cnt <= '0;
        end else if (idle) begin
            // Any cycle where the loader is absent or gets the grant restarts the count.
            if (!ldr_req || !cpu_req || force_ldr) begin
                fair_cnt <= '0;
            end else begin
                fair_cnt <= fair_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared 256x16 memory; the CPU has priority over the loader.
// Define MEM_ARB_FAIR_EN to build the fairness counter that bounds loader starvation.
module mem_arbiter
    import cpu_defs::*;
#(
    parameter int unsigned FAIR_LIMIT = FAIR_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [DAT_W-1:0] cpu_wdata,
    output logic [DAT_W-1:0] cpu_rdata,
    output logic             cpu_ack,
    input  logic             ldr_req,
    input  logic             ldr_we,
    input  logic [ADR_W-1:0] ldr_adr,
    input  logic [DAT_W-1:0] ldr_wdata,
    output logic [DAT_W-1:0] ldr_rdata,
    output logic             ldr_ack,
    output logic [ADR_W-1:0] mem_adr,
    output logic             mem_we,
    output logic [DAT_W-1:0] mem_wdata,
    input  logic [DAT_W-1:0] mem_rdata,
    output logic [7:0]       status
);

    arb_st_t          st;
    logic             owner;
    logic [CNT_W-1:0] fair_cnt;
    logic             force_ldr;
    logic             grant_ldr;

`ifdef MEM_ARB_FAIR_EN
    arb_fair_cnt #(
        .FAIR_LIMIT(FAIR_LIMIT)
    ) u_fair_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .idle     (st == IDLE),
        .cpu_req  (cpu_req),
        .ldr_req  (ldr_req),
        .fair_cnt (fair_cnt),
        .force_ldr(force_ldr)
    );
`else
    logic unused_fair_limit;
    assign unused_fair_limit = ^FAIR_LIMIT;
    assign fair_cnt          = '0;
    assign force_ldr         = 1'b0;
`endif

    assign grant_ldr = ldr_req & (~cpu_req | force_ldr);
    assign status    = {st, owner, fair_cnt, 2'b00};

    // The mem_* registers double as the request latches, so the access in flight is
    // immune to requester input changes after the IDLE sampling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= IDLE;
            owner     <= 1'b0;
            mem_adr   <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            mem_we  <= 1'b0;
            case (st)
                IDLE: begin
                    if (cpu_req || ldr_req) begin
                        owner     <= grant_ldr;
                        mem_adr   <= grant_ldr ? ldr_adr : cpu_adr;
                        mem_we    <= grant_ldr ? ldr_we : cpu_we;
                        mem_wdata <= grant_ldr ? ldr_wdata : cpu_wdata;
                        st        <= ACC;
                    end
                end
                ACC: begin
                    // mem_we still carries the latched direction during this cycle.
                    if (owner) begin
                        ldr_ack <= 1'b1;
                        if (!mem_we) ldr_rdata <= mem_rdata;
                    end else begin
                        cpu_ack <= 1'b1;
                        if (!mem_we) cpu_rdata <= mem_rdata;
                    end
                    st <= RSP;
                end
                RSP:     st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule
